cache_miss_ctrl: RTL and testbench
==================================

CACHE_MISS_CTRL -- requirements
Module: cache_miss_ctrl

Interface
REQ-001 SHALL provide parameters, one per line: name, default, meaning.
- ADDR_W, 32, byte address width.
- LINE_W, 512, line width in bits (64 B).
- TIMEOUT, 255, maximum cycles waiting for mem_ack per transfer.
REQ-002 SHALL provide ports, one per line: name, direction, width, meaning.
- clk, input, 1, clock.
- rst, input, 1, reset (asynchronous, active-high).
- miss, input, 1, cache miss pulse.
- dirty_evicted, input, 1, victim line is dirty; valid with miss.
- evicted_address, input, ADDR_W, victim line address.
- miss_address, input, ADDR_W, requested address.
- evict_data, input, LINE_W, victim line data; valid with miss.
- ram_ready, output, 1, one-cycle fill strobe to cache.
- ram_in, output, LINE_W, fill data; valid while ram_ready=1.
- busy, output, 1, miss in service; core stalls.
- mem_req, output, 1, RAM request.
- mem_we, output, 1, RAM request is a write.
- mem_addr, output, ADDR_W, line-aligned RAM address.
- mem_wdata, output, LINE_W, write-back data.
- mem_ack, input, 1, one-cycle RAM completion.
- mem_rdata, input, LINE_W, read data; valid with mem_ack on reads.
- err, output, 1, sticky timeout flag.
- miss_cnt, output, 16, saturating count of accepted misses.
- wb_cnt, output, 16, saturating count of completed write-backs.

Function
REQ-003 SHALL implement states IDLE, WB, FILL, DONE.
REQ-004 SHALL accept miss only in IDLE, capturing miss_address, evicted_address, evict_data and dirty_evicted on that edge. A miss seen outside IDLE SHALL be ignored.
REQ-005 SHALL transition on an accepted miss from IDLE to WB if dirty_evicted=1, else to FILL.
REQ-006 SHALL, in WB, drive mem_req=1, mem_we=1, mem_addr={evicted_address[ADDR_W-1:6],6'b0} and mem_wdata=captured data, all held stable until mem_ack. On mem_ack it SHALL go to FILL and increment wb_cnt.
REQ-007 SHALL, in FILL, drive mem_req=1, mem_we=0, mem_addr={miss_address[ADDR_W-1:6],6'b0}. On mem_ack it SHALL register mem_rdata into ram_in and go to DONE.
REQ-008 SHALL, in DONE, assert ram_ready=1 for exactly one cycle with ram_in valid, then return to IDLE.
REQ-009 SHALL drive busy=1 in every state except IDLE, and busy SHALL rise the cycle after miss is accepted.
REQ-010 SHALL drive mem_req=0 and mem_we=0 in IDLE and DONE. mem_req SHALL deassert the cycle after mem_ack.
REQ-011 SHALL ignore mem_ack when mem_req=0.
REQ-012 SHALL keep a wait counter that clears on state entry and increments each cycle in WB/FILL without mem_ack. On reaching TIMEOUT it SHALL set err=1, abort to IDLE without asserting ram_ready, and leave wb_cnt unchanged.
REQ-013 SHALL hold err=1 until reset. A later miss SHALL still be serviced normally.
REQ-014 SHALL increment miss_cnt on each accepted miss, saturating at 16'hFFFF. wb_cnt SHALL saturate identically.
REQ-015 SHALL, when miss and a mem_ack complete FILL on the same edge, not accept the miss (state is not IDLE).
REQ-016 SHALL give minimum latency from accepted miss to ram_ready of 3 cycles when clean and mem_ack is 1 cycle; dirty adds the write-back duration.

Reset
REQ-017 SHALL, on rst=1 at any time including mid-transfer, force IDLE and clear wait counter, busy, mem_req, mem_we, ram_ready, err, miss_cnt and wb_cnt. mem_addr, mem_wdata and ram_in SHALL reset to 0.
REQ-018 SHALL not assert ram_ready or mem_req in the first cycle after rst deasserts.

Verification
REQ-019 Clean miss at 0x0000_1234, RAM acks 2 cycles after request with rdata=A -> one read at mem_addr 0x0000_1200, ram_ready for 1 cycle with ram_in=A, miss_cnt=1, wb_cnt=0.
REQ-020 Dirty miss, evicted 0x0004_0040, miss 0x0000_2080 -> write at 0x0004_0040 with evict_data, then read at 0x0000_2080, wb_cnt=1, ram_ready once.
REQ-021 Second miss pulse while busy -> ignored, miss_cnt unchanged, single fill.
REQ-022 mem_ack never asserted -> err=1 after 255 wait cycles, busy=0, no ram_ready; next miss completes normally and err stays 1.
REQ-023 rst asserted during WB with mem_req=1 -> same cycle mem_req=0, busy=0, counters=0; post-reset miss services correctly.
REQ-024 Stray mem_ack in IDLE -> no state change, no ram_ready.

Source files
------------

// File: rtl/cache_miss_ctrl.sv
// -----------------------------------------------------------------------------
// cache_miss_ctrl
//
// Services one cache miss at a time against a line-granular RAM port.
// A miss is taken only while idle. A dirty victim is written back first,
// then the requested line is read, and the fill is handed to the cache with
// a single-cycle ram_ready strobe. Each RAM transfer is guarded by a wait
// counter. If mem_ack does not arrive in time, the transfer is abandoned,
// the sticky err flag is raised, and the controller returns to idle without
// filling.
//
// Parameters
//   ADDR_W  : byte address width
//   LINE_W  : cache line width in bits (64-byte lines)
//   TIMEOUT : maximum cycles spent waiting for mem_ack on one transfer
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   miss            : miss pulse from the cache (taken only when idle)
//   dirty_evicted   : victim is dirty, qualified by miss
//   evicted_address : victim line address, qualified by miss
//   miss_address    : requested address, qualified by miss
//   evict_data      : victim line data, qualified by miss
//   ram_ready       : one-cycle fill strobe to the cache
//   ram_in          : fill data, valid while ram_ready is high
//   busy            : miss in service, core stalls
//   mem_req/mem_we  : RAM request / request is a write
//   mem_addr        : line-aligned RAM address
//   mem_wdata       : write-back data
//   mem_ack         : one-cycle RAM completion
//   mem_rdata       : read data, qualified by mem_ack on reads
//   err             : sticky timeout flag
//   miss_cnt        : saturating count of accepted misses
//   wb_cnt          : saturating count of completed write-backs
// -----------------------------------------------------------------------------
module cache_miss_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 512,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss,
    input  logic              dirty_evicted,
    input  logic [ADDR_W-1:0] evicted_address,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic [LINE_W-1:0] evict_data,
    output logic              ram_ready,
    output logic [LINE_W-1:0] ram_in,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              err,
    output logic [15:0]       miss_cnt,
    output logic [15:0]       wb_cnt
);

    // 64-byte lines: the low six address bits select a byte inside the line.
    localparam int OFF_W  = 6;
    // The counter only has to hold 0..TIMEOUT-1, because reaching TIMEOUT aborts.
    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                    state_q;
    logic [WAIT_W-1:0]         wait_q;
    logic [ADDR_W-OFF_W-1:0]   miss_line_q;
    logic                      busy_q;
    logic                      mem_req_q;
    logic                      mem_we_q;
    logic [ADDR_W-1:0]         mem_addr_q;
    logic [LINE_W-1:0]         mem_wdata_q;
    logic                      ram_ready_q;
    logic [LINE_W-1:0]         ram_in_q;
    logic                      err_q;
    logic [15:0]               miss_cnt_q;
    logic [15:0]               wb_cnt_q;

    logic [15:0]               miss_cnt_d;
    logic [15:0]               wb_cnt_d;
    logic [WAIT_W-1:0]         wait_d;
    logic                      timeout_hit;

    // The byte offsets are irrelevant for line transfers. They are folded here
    // so the unused input bits are visibly accounted for.
    logic                      unused_offsets;
    assign unused_offsets = ^{evicted_address[OFF_W-1:0], miss_address[OFF_W-1:0]};

    assign miss_cnt_d  = (miss_cnt_q == 16'hFFFF) ? miss_cnt_q : miss_cnt_q + 16'd1;
    assign wb_cnt_d    = (wb_cnt_q   == 16'hFFFF) ? wb_cnt_q   : wb_cnt_q   + 16'd1;
    assign wait_d      = wait_q + {{(WAIT_W-1){1'b0}}, 1'b1};
    // This cycle without an ack would be the TIMEOUT-th one for the transfer.
    assign timeout_hit = (wait_q == WAIT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wait_q      <= '0;
            miss_line_q <= '0;
            busy_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ram_ready_q <= 1'b0;
            ram_in_q    <= '0;
            err_q       <= 1'b0;
            miss_cnt_q  <= '0;
            wb_cnt_q    <= '0;
        end else begin
            // The fill strobe is high only for the single cycle spent in DONE.
            ram_ready_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    // mem_ack cannot matter here: no request is outstanding.
                    if (miss) begin
                        miss_cnt_q  <= miss_cnt_d;
                        busy_q      <= 1'b1;
                        mem_req_q   <= 1'b1;
                        wait_q      <= '0;
                        miss_line_q <= miss_address[ADDR_W-1:OFF_W];
                        mem_wdata_q <= evict_data;
                        if (dirty_evicted) begin
                            state_q    <= WB;
                            mem_we_q   <= 1'b1;
                            mem_addr_q <= {evicted_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        end else begin
                            state_q    <= FILL;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= {miss_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        end
                    end
                end

                WB: begin
                    if (mem_ack) begin
                        // Start the read right away. mem_req stays high and
                        // only the direction and address change.
                        state_q    <= FILL;
                        wb_cnt_q   <= wb_cnt_d;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= {miss_line_q, {OFF_W{1'b0}}};
                        wait_q     <= '0;
                    end else if (timeout_hit) begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        err_q     <= 1'b1;
                        wait_q    <= '0;
                    end else begin
                        wait_q <= wait_d;
                    end
                end

                FILL: begin
                    if (mem_ack) begin
                        state_q     <= DONE;
                        ram_in_q    <= mem_rdata;
                        ram_ready_q <= 1'b1;
                        mem_req_q   <= 1'b0;
                        wait_q      <= '0;
                    end else if (timeout_hit) begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        err_q     <= 1'b1;
                        wait_q    <= '0;
                    end else begin
                        wait_q <= wait_d;
                    end
                end

                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    wait_q  <= '0;
                end

                default: begin
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                    wait_q    <= '0;
                end
            endcase
        end
    end

    assign ram_ready = ram_ready_q;
    assign ram_in    = ram_in_q;
    assign busy      = busy_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign err       = err_q;
    assign miss_cnt  = miss_cnt_q;
    assign wb_cnt    = wb_cnt_q;

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_miss_ctrl
//
// Directed bench for cache_miss_ctrl. Stimulus pushes the RAM requests and
// fills it expects into a scoreboard queue. A monitor pops the queue whenever
// the DUT starts a RAM transfer or strobes ram_ready. A small RAM model acks
// after a programmable delay. It can be disabled to provoke timeouts, or made
// to emit a stray ack while the controller is idle.
// -----------------------------------------------------------------------------
module tb_cache_miss_ctrl;

    localparam int AW = 32;
    localparam int LW = 512;

    logic          clk = 1'b0;
    logic          rst;
    logic          miss;
    logic          dirty_evicted;
    logic [AW-1:0] evicted_address;
    logic [AW-1:0] miss_address;
    logic [LW-1:0] evict_data;
    logic          ram_ready;
    logic [LW-1:0] ram_in;
    logic          busy;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] mem_wdata;
    logic          mem_ack;
    logic [LW-1:0] mem_rdata;
    logic          err;
    logic [15:0]   miss_cnt;
    logic [15:0]   wb_cnt;

    cache_miss_ctrl #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .miss(miss), .dirty_evicted(dirty_evicted),
        .evicted_address(evicted_address), .miss_address(miss_address),
        .evict_data(evict_data), .ram_ready(ram_ready), .ram_in(ram_in),
        .busy(busy), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .err(err), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            fill;
        bit            we;
        logic [AW-1:0] addr;
        logic [LW-1:0] data;
    } exp_t;

    exp_t q[$];
    int   vectors;
    int   miscompares;
    bit   ram_en;
    int   ack_delay;
    bit   stray_ack;
    logic [LW-1:0] rdata_v;
    int   exp_miss;
    int   exp_wb;
    int   ncyc;

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_req(input bit we, input logic [AW-1:0] a, input logic [LW-1:0] d);
        exp_t e;
        e.fill = 1'b0; e.we = we; e.addr = a; e.data = d;
        q.push_back(e);
    endtask

    task automatic push_fill(input logic [LW-1:0] d);
        exp_t e;
        e.fill = 1'b1; e.we = 1'b0; e.addr = '0; e.data = d;
        q.push_back(e);
    endtask

    // Returns at the negedge that follows the accepting posedge, with miss low.
    task automatic issue_miss(input logic [AW-1:0] ma, input logic [AW-1:0] ea,
                              input bit d, input logic [LW-1:0] ed);
        @(negedge clk);
        miss = 1'b1; miss_address = ma; evicted_address = ea;
        dirty_evicted = d; evict_data = ed;
        @(negedge clk);
        miss = 1'b0;
    endtask

    task automatic wait_idle(input int bound, output int n);
        n = 0;
        while (busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_idle: busy still 1 after %0d cycles, required 0", bound);
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        ram_en = 1'b1; ack_delay = 0; stray_ack = 1'b0; rdata_v = '0;
        exp_miss = 0; exp_wb = 0;
        rst = 1'b1; miss = 1'b0; dirty_evicted = 1'b0;
        evicted_address = '0; miss_address = '0; evict_data = '0;
        mem_ack = 1'b0; mem_rdata = '0;

        fork
            // Scoreboard monitor: sample 1 time unit after each active edge.
            begin
                exp_t e;
                bit   prev_req;
                prev_req = 1'b0;
                forever begin
                    @(posedge clk);
                    #1;
                    if (mem_req && (!prev_req || mem_ack)) begin
                        vectors++;
                        if (q.size() == 0) begin
                            miscompares++;
                            $display("FAIL unexpected_req: got we=%0b addr=%0h, none expected", mem_we, mem_addr);
                        end else begin
                            e = q.pop_front();
                            if (e.fill || mem_we !== e.we || mem_addr !== e.addr ||
                                (e.we && mem_wdata !== e.data)) begin
                                miscompares++;
                                $display("FAIL mem_req: got we=%0b addr=%0h wdata=%0h expected fill=%0b we=%0b addr=%0h wdata=%0h",
                                         mem_we, mem_addr, mem_wdata, e.fill, e.we, e.addr, e.data);
                            end
                        end
                    end
                    if (ram_ready) begin
                        vectors++;
                        if (q.size() == 0) begin
                            miscompares++;
                            $display("FAIL unexpected_fill: got ram_in=%0h, none expected", ram_in);
                        end else begin
                            e = q.pop_front();
                            if (!e.fill || ram_in !== e.data) begin
                                miscompares++;
                                $display("FAIL ram_fill: got ram_in=%0h expected fill=1 data=%0h", ram_in, e.data);
                            end
                        end
                    end
                    prev_req = mem_req;
                end
            end
            // RAM model: ack after ack_delay extra request cycles.
            begin
                int wc;
                wc = 0;
                forever begin
                    @(negedge clk);
                    if (mem_ack) begin
                        mem_ack = 1'b0;
                        wc = 0;
                    end
                    if (mem_req && ram_en) begin
                        if (wc >= ack_delay) begin
                            mem_ack   = 1'b1;
                            mem_rdata = rdata_v;
                        end else begin
                            wc++;
                        end
                    end else begin
                        wc = 0;
                        if (stray_ack) begin
                            mem_ack   = 1'b1;
                            mem_rdata = {16{32'hDEAD_BEEF}};
                            stray_ack = 1'b0;
                        end
                    end
                end
            end
            // Global watchdog.
            begin
                #1_000_000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        // Check the reset state.
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_ram_ready", ram_ready, 0);
        chk("rst_err", err, 0);
        chk("rst_miss_cnt", miss_cnt, 0);
        chk("rst_wb_cnt", wb_cnt, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_ram_in", ram_in, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_mem_req", mem_req, 0);
        chk("post_rst_ram_ready", ram_ready, 0);

        // Clean miss, ack two cycles late.
        ack_delay = 2; rdata_v = {16{32'hAAAA_0001}};
        push_req(1'b0, 32'h0000_1200, '0);
        push_fill(rdata_v);
        issue_miss(32'h0000_1234, 32'h0000_9000, 1'b0, {16{32'h1111_1111}});
        exp_miss++;
        chk("clean_busy_rise", busy, 1);
        wait_idle(50, ncyc);
        chk("clean_miss_cnt", miss_cnt, 16'(exp_miss));
        chk("clean_wb_cnt", wb_cnt, 16'(exp_wb));

        // Minimum latency: clean miss, one-cycle ack.
        ack_delay = 0; rdata_v = {16{32'hBBBB_0002}};
        push_req(1'b0, 32'h0000_3000, '0);
        push_fill(rdata_v);
        issue_miss(32'h0000_3004, 32'h0000_0000, 1'b0, '0);
        exp_miss++;
        chk("lat_fill_cycle_ready", ram_ready, 0);
        @(negedge clk);
        chk("lat_done_ready", ram_ready, 1);
        chk("lat_done_data", ram_in, {16{32'hBBBB_0002}});
        wait_idle(50, ncyc);

        // Dirty miss: write-back, then read.
        ack_delay = 1; rdata_v = {16{32'hCCCC_0003}};
        push_req(1'b1, 32'h0004_0040, {16{32'h5A5A_0004}});
        push_req(1'b0, 32'h0000_2080, '0);
        push_fill(rdata_v);
        issue_miss(32'h0000_2080, 32'h0004_0040, 1'b1, {16{32'h5A5A_0004}});
        exp_miss++; exp_wb++;
        wait_idle(50, ncyc);
        chk("dirty_wb_cnt", wb_cnt, 16'(exp_wb));
        chk("dirty_miss_cnt", miss_cnt, 16'(exp_miss));

        // Second miss pulse while busy is ignored.
        ack_delay = 3; rdata_v = {16{32'hDDDD_0005}};
        push_req(1'b0, 32'h0000_5000, '0);
        push_fill(rdata_v);
        issue_miss(32'h0000_5010, 32'h0000_0000, 1'b0, '0);
        exp_miss++;
        @(negedge clk);
        miss = 1'b1; miss_address = 32'h0000_7700; dirty_evicted = 1'b1;
        evicted_address = 32'h0000_8800;
        @(negedge clk);
        miss = 1'b0;
        wait_idle(50, ncyc);
        chk("busy_miss_cnt", miss_cnt, 16'(exp_miss));
        chk("busy_wb_cnt", wb_cnt, 16'(exp_wb));

        // A miss on the same edge as the FILL ack is not accepted.
        ack_delay = 0; rdata_v = {16{32'hEEEE_0006}};
        push_req(1'b0, 32'h0000_6000, '0);
        push_fill(rdata_v);
        issue_miss(32'h0000_6020, 32'h0000_0000, 1'b0, '0);
        exp_miss++;
        miss = 1'b1; miss_address = 32'h0000_9900; dirty_evicted = 1'b0;
        @(negedge clk);
        miss = 1'b0;
        wait_idle(50, ncyc);
        repeat (2) @(negedge clk);
        chk("ack_edge_miss_cnt", miss_cnt, 16'(exp_miss));
        chk("ack_edge_busy", busy, 0);

        // Stray ack while idle.
        stray_ack = 1'b1;
        repeat (4) @(negedge clk);
        chk("stray_busy", busy, 0);
        chk("stray_mem_req", mem_req, 0);
        chk("stray_miss_cnt", miss_cnt, 16'(exp_miss));

        // Timeout: no ack ever arrives.
        ram_en = 1'b0;
        push_req(1'b0, 32'h0001_0000, '0);
        issue_miss(32'h0001_0008, 32'h0000_0000, 1'b0, '0);
        exp_miss++;
        chk("to_err_early", err, 0);
        wait_idle(400, ncyc);
        chk("to_cycles", ncyc, 255);
        chk("to_err", err, 1);
        chk("to_busy", busy, 0);
        chk("to_mem_req", mem_req, 0);
        chk("to_wb_cnt", wb_cnt, 16'(exp_wb));
        // The next miss is still serviced, and err stays set.
        ram_en = 1'b1; ack_delay = 1; rdata_v = {16{32'h1234_0007}};
        push_req(1'b0, 32'h0002_0040, '0);
        push_fill(rdata_v);
        issue_miss(32'h0002_0044, 32'h0000_0000, 1'b0, '0);
        exp_miss++;
        wait_idle(50, ncyc);
        chk("after_to_err", err, 1);
        chk("after_to_miss_cnt", miss_cnt, 16'(exp_miss));

        // Reset in the middle of a write-back.
        ram_en = 1'b0;
        push_req(1'b1, 32'h0003_0080, {16{32'h7777_0008}});
        issue_miss(32'h0000_4000, 32'h0003_00BF, 1'b1, {16{32'h7777_0008}});
        repeat (2) @(negedge clk);
        chk("mid_wb_req", mem_req, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_mem_req", mem_req, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_miss_cnt", miss_cnt, 0);
        chk("rst_mid_wb_cnt", wb_cnt, 0);
        chk("rst_mid_err", err, 0);
        @(negedge clk);
        rst = 1'b0; ram_en = 1'b1; exp_miss = 0; exp_wb = 0;
        @(negedge clk);
        chk("rel_mem_req", mem_req, 0);
        chk("rel_ram_ready", ram_ready, 0);
        ack_delay = 1; rdata_v = {16{32'h9999_0009}};
        push_req(1'b1, 32'h0003_0080, {16{32'h6666_000A}});
        push_req(1'b0, 32'h0000_4000, '0);
        push_fill(rdata_v);
        issue_miss(32'h0000_4000, 32'h0003_0080, 1'b1, {16{32'h6666_000A}});
        exp_miss++; exp_wb++;
        wait_idle(50, ncyc);
        chk("post_rst_miss_cnt", miss_cnt, 16'(exp_miss));
        chk("post_rst_wb_cnt", wb_cnt, 16'(exp_wb));

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
